// File: rtl/vector_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_serializer_pkg
// Description : Shared vector geometry (capacity, element width, ARR type)
//               and serializer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef MAX_NEURONS
`define MAX_NEURONS 4
`endif

package vector_serializer_pkg;

    localparam int MAX_NEURONS = `MAX_NEURONS;
    localparam int DATA_WIDTH  = 16;
    // Guard keeps a 1-element build from collapsing the index to zero bits.
    localparam int IDX_W       = (MAX_NEURONS > 1) ? $clog2(MAX_NEURONS) : 1;

    typedef logic [MAX_NEURONS-1:0][DATA_WIDTH-1:0] arr_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/vector_serializer.sv
`default_nettype none
// ============================================================================
// Module      : vector_serializer
// Description : Captures a parallel ARR vector and streams its first in_len
//               elements out one per cycle over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================

module vector_serializer #(
    parameter int DATA_WIDTH = vector_serializer_pkg::DATA_WIDTH,
    parameter int N          = vector_serializer_pkg::MAX_NEURONS,
    parameter int IDX_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N-1:0][DATA_WIDTH-1:0]   in_vec,
    input  logic [IDX_W:0]                 in_len,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [IDX_W-1:0]               out_idx,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           done
);

    import vector_serializer_pkg::*;

    localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(N);

    ser_state_t                      state;
    ser_state_t                      state_nxt;
    logic [N-1:0][DATA_WIDTH-1:0]    vec_buf;
    logic [IDX_W-1:0]                idx;
    logic [IDX_W-1:0]                idx_nxt;
    logic [IDX_W:0]                  len_q;
    logic [IDX_W:0]                  len_clamped;
    logic                            ready_q;
    logic                            done_q;
    logic                            done_nxt;
    logic                            accept;
    logic                            at_last;

    assign accept      = in_valid & ready_q;
    assign len_clamped = (in_len > LEN_MAX) ? LEN_MAX : in_len;
    // len_q-1 wraps to all-ones when len_q==0, so no index can match then.
    assign at_last     = ({1'b0, idx} == (len_q - 1'b1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    idx_nxt = '0;
                    if (len_clamped == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = STREAM;
                    end
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (at_last) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // in_ready is its own flop so it stays low throughout reset and rises on
    // the first edge after release, together with every return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_buf <= '0;
            len_q   <= '0;
            idx     <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            idx     <= idx_nxt;
            done_q  <= done_nxt;
            ready_q <= (state_nxt == IDLE);
            if ((state == IDLE) && accept) begin
                vec_buf <= in_vec;
                len_q   <= len_clamped;
            end
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state == STREAM);
    assign out_data  = (state == STREAM) ? vec_buf[idx] : '0;
    assign out_idx   = idx;
    assign out_last  = (state == STREAM) & at_last;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_vector_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_serializer
// Description : Self-checking bench: vector table, hand-written corner cases
//               and randomized vectors against an element-queue model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_vector_serializer;

    import vector_serializer_pkg::*;

    localparam int N  = MAX_NEURONS;
    localparam int DW = DATA_WIDTH;
    localparam int IW = IDX_W;

    logic              clk;
    logic              rst_n;
    arr_t              in_vec;
    logic [IW:0]       in_len;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_idx;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              done;

    int n_tests = 0;
    int n_fail  = 0;

    vector_serializer #(
        .DATA_WIDTH (DW),
        .N          (N),
        .IDX_W      (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vec    (in_vec),
        .in_len    (in_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic arr_t mk(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [DW-1:0] c, input logic [DW-1:0] d);
        arr_t v;
        v[0] = a;
        v[1] = b;
        v[2] = c;
        v[3] = d;
        return v;
    endfunction

    // Model: a vector of length len yields elements v[0..min(len,N)-1] in order,
    // then done and in_ready together on the cycle after the last transfer.
    task automatic run_vector(input arr_t v, input int len, input int stall_pct,
                              input int stall_at, input int stall_n,
                              input bit hold, input arr_t alt,
                              output int n_out, output logic [DW-1:0] last_seen);
        logic [DW-1:0] exp_q[$];
        int exp_len;
        int k;
        int budget;
        int stalls;
        exp_len   = (len > N) ? N : len;
        for (int i = 0; i < exp_len; i++) exp_q.push_back(v[i]);
        last_seen = '0;
        budget    = 0;
        while (!in_ready && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        in_vec   = v;
        in_len   = (IW+1)'(len);
        in_valid = 1'b1;
        @(posedge clk); #1;
        if (hold) in_vec = alt;
        else      in_valid = 1'b0;
        if (exp_len == 0) begin
            chk("zero_valid", {31'd0, out_valid}, 32'd0);
            chk("zero_done",  {31'd0, done},      32'd1);
            chk("zero_ready", {31'd0, in_ready},  32'd1);
            n_out = 0;
            return;
        end
        k = 0;
        stalls = 0;
        budget = 0;
        while (k < exp_len && budget < 200) begin
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            chk("done_busy", {31'd0, done}, 32'd0);
            chk("out_data", 32'(out_data), 32'(exp_q[k]));
            chk("out_idx", 32'(out_idx), 32'(k));
            chk("out_last", {31'd0, out_last}, (k == exp_len - 1) ? 32'd1 : 32'd0);
            if (k == stall_at && stalls < stall_n) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = ($urandom_range(99) >= stall_pct);
            end
            @(posedge clk); #1;
            if (out_ready) begin
                if (k == exp_len - 1) last_seen = exp_q[k];
                k++;
            end
            budget++;
        end
        chk("stream_complete", 32'(k), 32'(exp_len));
        out_ready = 1'b1;
        chk("done_pulse",  {31'd0, done},      32'd1);
        chk("end_valid",   {31'd0, out_valid}, 32'd0);
        chk("end_ready",   {31'd0, in_ready},  32'd1);
        n_out = k;
    endtask

    typedef struct {
        arr_t          vec;
        int            len;
        int            stall_pct;
        int            exp_count;
        logic [DW-1:0] exp_last;
    } vec_rec_t;

    vec_rec_t tbl[6];

    initial begin
        int            n_out;
        logic [DW-1:0] last_seen;
        arr_t          v;
        int            len;

        rst_n     = 1'b1;
        in_vec    = '0;
        in_len    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data",  32'(out_data),      32'd0);
        chk("rst_out_idx",   32'(out_idx),       32'd0);
        chk("rst_done",      {31'd0, done},      32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        tbl[0] = '{mk(16'd10, 16'd20, 16'd30, 16'd40), 4, 0,  4, 16'd40};
        tbl[1] = '{mk(16'd10, 16'd20, 16'd30, 16'd40), 2, 0,  2, 16'd20};
        tbl[2] = '{mk(16'd10, 16'd20, 16'd30, 16'd40), 0, 0,  0, 16'd0};
        tbl[3] = '{mk(16'd10, 16'd20, 16'd30, 16'd40), 7, 0,  4, 16'd40};
        tbl[4] = '{mk(16'hffff, 16'h8000, 16'h0001, 16'h0000), 3, 30, 3, 16'h0001};
        tbl[5] = '{mk(16'h1234, 16'h5678, 16'h9abc, 16'hdef0), 1, 0,  1, 16'h1234};

        for (int t = 0; t < 6; t++) begin
            run_vector(tbl[t].vec, tbl[t].len, tbl[t].stall_pct, -1, 0, 1'b0, '0, n_out, last_seen);
            chk("tbl_count", 32'(n_out), 32'(tbl[t].exp_count));
            chk("tbl_last",  32'(last_seen), 32'(tbl[t].exp_last));
        end

        // Backpressure: three stall cycles while element 20 is presented.
        run_vector(mk(16'd10, 16'd20, 16'd30, 16'd40), 4, 0, 1, 3, 1'b0, '0, n_out, last_seen);
        chk("bp_count", 32'(n_out), 32'd4);

        // Input isolation: in_vec switched and in_valid held during the stream.
        run_vector(mk(16'd10, 16'd20, 16'd30, 16'd40), 4, 0, -1, 0, 1'b1,
                   mk(16'd1, 16'd2, 16'd3, 16'd4), n_out, last_seen);
        chk("iso_last1", 32'(last_seen), 32'd40);
        run_vector(mk(16'd1, 16'd2, 16'd3, 16'd4), 4, 0, -1, 0, 1'b0, '0, n_out, last_seen);
        chk("iso_last2", 32'(last_seen), 32'd4);

        // Reset mid-stream after element 20 has been transferred.
        in_vec    = mk(16'd10, 16'd20, 16'd30, 16'd40);
        in_len    = 3'd4;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_first", 32'(out_data), 32'd10);
        @(posedge clk); #1;
        chk("mid_second", 32'(out_data), 32'd20);
        @(posedge clk); #1;
        chk("mid_pre_rst", 32'(out_data), 32'd30);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data",  32'(out_data),      32'd0);
        chk("mid_rst_done",  {31'd0, done},      32'd0);
        chk("mid_rst_ready", {31'd0, in_ready},  32'd0);
        @(posedge clk); #1;
        chk("mid_rst_hold_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rel_done",  {31'd0, done},     32'd0);
        run_vector(mk(16'd5, 16'd6, 16'd7, 16'd8), 4, 0, -1, 0, 1'b0, '0, n_out, last_seen);
        chk("mid_restart_last", 32'(last_seen), 32'd8);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) v[i] = DW'($urandom);
            len = int'($urandom_range(2**(IW+1) - 1));
            run_vector(v, len, int'($urandom_range(60)), -1, 0, 1'b0, '0, n_out, last_seen);
            chk("rnd_count", 32'(n_out), 32'((len > N) ? N : len));
            chk("rnd_last", 32'(last_seen), (len == 0) ? 32'd0 : 32'(v[((len > N) ? N : len) - 1]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
